// File: rtl/shift_arith_sequencer_pkg.sv
// Shared definitions for the shift/arith sequencer slice.
//   WIDTH / MUL_ITERS : operand width and multiply loop length (tied together)
//   OP_*              : opcode values carried on the command bus
//   ST_*              : sequencer state encoding
//   unit_out_t        : value/carry bundle returned by the combinational unit
package shift_arith_sequencer_pkg;

  localparam int WIDTH     = 4;
  localparam int MUL_ITERS = WIDTH;
  localparam int CNT_W     = $clog2(MUL_ITERS);

  localparam logic [2:0] OP_LSL    = 3'd0;
  localparam logic [2:0] OP_ASR    = 3'd1;
  localparam logic [2:0] OP_CONCAT = 3'd2;
  localparam logic [2:0] OP_ADD    = 3'd3;
  localparam logic [2:0] OP_MUL    = 3'd4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_MUL  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic [2*WIDTH-1:0] value;
    logic               carry;
  } unit_out_t;

  // Opcodes 0..3 finish in the combinational unit in a single EXEC cycle.
  function automatic logic op_is_single(input logic [2:0] op);
    return (op <= OP_ADD);
  endfunction

endpackage

// File: rtl/shift_arith_sequencer_if.sv
// Command/result bus between a command source and the sequencer.
//   start, op, a, b                   : command side (driven by master)
//   busy, done, result, carry, err    : status/result side (driven by slave)
interface shift_arith_sequencer_if;
  import shift_arith_sequencer_pkg::*;

  logic               start;
  logic [2:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               carry;
  logic               err;

  modport master (
    output start, op, a, b,
    input  busy, done, result, carry, err
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, carry, err
  );

endinterface

// File: rtl/shift_arith_unit.sv
// Combinational datapath for the single-cycle opcodes.
//   a, b  : latched operands
//   op    : latched opcode (only 0..3 produce a value, others give zero)
//   out   : 2*WIDTH-bit value plus ADD carry-out
module shift_arith_unit
  import shift_arith_sequencer_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output unit_out_t        out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] lsl;

  assign sum = {1'b0, a} + {1'b0, b};
  assign lsl = {a[WIDTH-2:0], 1'b0};

  always_comb begin
    out.value = '0;
    out.carry = 1'b0;
    case (op)
      OP_LSL:    out.value = {{WIDTH{1'b0}}, lsl};
      OP_ASR:    out.value = {{WIDTH{1'b0}}, a[WIDTH-1], a[WIDTH-1:1]};
      OP_CONCAT: out.value = {a, lsl};
      OP_ADD: begin
        out.value = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
        out.carry = sum[WIDTH];
      end
      default: begin
        out.value = '0;
        out.carry = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_arith_sequencer.sv
// Multi-cycle command sequencer over a small shift/add datapath.
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high, clears all state
//   bus    : slave side of the command/result bus (start/op/a/b in,
//            busy/done/result/carry/err out)
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | waiting for start; latches op/a/b on accept
//   EXEC    | single-cycle op: load result/carry from shift_arith_unit
//   MUL     | shift-and-add loop, one multiplier bit per cycle
//   DONE    | done pulse for one cycle, start ignored here
module shift_arith_sequencer
  import shift_arith_sequencer_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  shift_arith_sequencer_if.slave bus
);

  logic [1:0]         state;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] result_q;
  logic               carry_q;
  logic               err_q;

  logic [2*WIDTH-1:0] acc_next;
  unit_out_t          unit_out;

  shift_arith_unit u_unit (
    .a   (a_q),
    .b   (b_q),
    .op  (op_q),
    .out (unit_out)
  );

  // Partial product added only when the current multiplier LSB is set.
  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      count    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            op_q  <= bus.op;
            a_q   <= bus.a;
            b_q   <= bus.b;
            err_q <= 1'b0;
            if (op_is_single(bus.op)) begin
              state <= ST_EXEC;
            end else if (bus.op == OP_MUL) begin
              state  <= ST_MUL;
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, bus.a};
              mplier <= bus.b;
              count  <= '0;
            end else begin
              // Illegal opcode: straight to DONE, previous result kept.
              state   <= ST_DONE;
              err_q   <= 1'b1;
              carry_q <= 1'b0;
            end
          end
        end

        ST_EXEC: begin
          result_q <= unit_out.value;
          carry_q  <= unit_out.carry;
          state    <= ST_DONE;
        end

        ST_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (count == CNT_W'(MUL_ITERS - 1)) begin
            result_q <= acc_next;
            carry_q  <= 1'b0;
            state    <= ST_DONE;
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = (state != ST_IDLE);
  assign bus.done   = (state == ST_DONE);
  assign bus.result = result_q;
  assign bus.carry  = carry_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_shift_arith_sequencer.sv
module tb_shift_arith_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shift_arith_sequencer_if bus_if ();

  shift_arith_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: each accepted command occupies a fixed number of
  // cycles (latency), outputs update when its done cycle begins.
  int         m_rem = 0;
  logic [7:0] m_result = 8'h00;
  logic       m_carry = 1'b0;
  logic       m_err = 1'b0;
  logic [7:0] p_result;
  logic       p_carry;
  logic       p_err;

  function automatic void model_eval(input logic [2:0] op, input logic [3:0] a,
                                     input logic [3:0] b, input logic [7:0] prev,
                                     output logic [7:0] r, output logic c,
                                     output logic e, output int lat);
    int ai;
    int bi;
    ai = int'(a);
    bi = int'(b);
    c = 1'b0;
    e = 1'b0;
    lat = 2;
    case (op)
      3'd0: r = 8'((ai * 2) % 16);
      3'd1: r = 8'(ai / 2 + ((ai >= 8) ? 8 : 0));
      3'd2: r = 8'(ai * 16 + (ai * 2) % 16);
      3'd3: begin
        r = 8'((ai + bi) % 16);
        c = ((ai + bi) >= 16);
      end
      3'd4: begin
        r = 8'(ai * bi);
        lat = 5;
      end
      default: begin
        r = prev;
        e = 1'b1;
        lat = 1;
      end
    endcase
  endfunction

  always @(posedge clk) begin
    int lat;
    if (reset) begin
      m_rem = 0;
      m_result = 8'h00;
      m_carry = 1'b0;
      m_err = 1'b0;
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1;
      if (m_rem == 1) begin
        m_result = p_result;
        m_carry = p_carry;
        m_err = p_err;
      end
    end else if (bus_if.start) begin
      model_eval(bus_if.op, bus_if.a, bus_if.b, m_result, p_result, p_carry, p_err, lat);
      m_err = 1'b0;
      m_rem = lat;
      if (lat == 1) begin
        m_result = p_result;
        m_carry = p_carry;
        m_err = p_err;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", bus_if.busy, m_rem > 0);
      check("done", bus_if.done, m_rem == 1);
      check("result", bus_if.result, m_result);
      check("carry", bus_if.carry, m_carry);
      check("err", bus_if.err, m_err);
    end
  end

  // One command: start for one cycle, scramble inputs afterwards, wait for done.
  task automatic run_cmd(input string name, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [7:0] exp_r,
                         input logic exp_c, input logic exp_e, input int exp_lat);
    int got;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.op = op;
    bus_if.a = a;
    bus_if.b = b;
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.a = ~a;
    bus_if.b = 4'($urandom);
    bus_if.op = 3'($urandom_range(0, 7));
    got = 0;
    for (int c = 1; c <= 20; c++) begin
      if (bus_if.done) begin
        got = c;
        break;
      end
      @(negedge clk);
    end
    check({name, "_latency"}, got, exp_lat);
    check({name, "_result"}, bus_if.result, exp_r);
    check({name, "_carry"}, bus_if.carry, exp_c);
    check({name, "_err"}, bus_if.err, exp_e);
    @(negedge clk);
    check({name, "_done_width"}, bus_if.done, 1'b0);
  endtask

  initial begin
    int got;
    int n_done;
    reset = 1'b1;
    bus_if.start = 1'b0;
    bus_if.op = 3'd0;
    bus_if.a = 4'h0;
    bus_if.b = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus_if.busy, 1'b0);
    check("rst_done", bus_if.done, 1'b0);
    check("rst_result", bus_if.result, 8'h00);
    check("rst_carry", bus_if.carry, 1'b0);
    check("rst_err", bus_if.err, 1'b0);
    reset = 1'b0;
    chk_en = 1'b1;

    run_cmd("lsl", 3'd0, 4'b1011, 4'h0, 8'h06, 1'b0, 1'b0, 2);
    run_cmd("asr_neg", 3'd1, 4'b1010, 4'h0, 8'h0D, 1'b0, 1'b0, 2);
    run_cmd("asr_pos", 3'd1, 4'h6, 4'h0, 8'h03, 1'b0, 1'b0, 2);
    run_cmd("concat", 3'd2, 4'hB, 4'h0, 8'hB6, 1'b0, 1'b0, 2);
    run_cmd("add_wrap", 3'd3, 4'hF, 4'h1, 8'h00, 1'b1, 1'b0, 2);
    run_cmd("add", 3'd3, 4'h3, 4'h4, 8'h07, 1'b0, 1'b0, 2);
    run_cmd("mul_ff", 3'd4, 4'hF, 4'hF, 8'hE1, 1'b0, 1'b0, 5);
    run_cmd("mul_zero", 3'd4, 4'h0, 4'h9, 8'h00, 1'b0, 1'b0, 5);
    run_cmd("mul_9x13", 3'd4, 4'h9, 4'hD, 8'h75, 1'b0, 1'b0, 5);

    // Second start during MUL must be ignored.
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.op = 3'd4; bus_if.a = 4'h6; bus_if.b = 4'h7;
    @(negedge clk);
    bus_if.start = 1'b0;
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.op = 3'd3; bus_if.a = 4'hF; bus_if.b = 4'hF;
    @(negedge clk);
    bus_if.start = 1'b0;
    got = 0;
    for (int c = 3; c <= 20; c++) begin
      if (bus_if.done) begin
        got = c;
        break;
      end
      @(negedge clk);
    end
    check("repulse_latency", got, 5);
    check("repulse_result", bus_if.result, 8'h2A);
    @(negedge clk);
    check("repulse_idle", bus_if.busy, 1'b0);

    // Reset on the second MUL cycle aborts without a done pulse.
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.op = 3'd4; bus_if.a = 4'h5; bus_if.b = 4'h5;
    @(negedge clk);
    bus_if.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", bus_if.busy, 1'b0);
    check("abort_result", bus_if.result, 8'h00);
    reset = 1'b0;
    n_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus_if.done) n_done++;
    end
    check("abort_no_done", n_done, 0);

    run_cmd("pre_illegal", 3'd3, 4'h3, 4'h4, 8'h07, 1'b0, 1'b0, 2);
    run_cmd("illegal", 3'd6, 4'h2, 4'h2, 8'h07, 1'b0, 1'b1, 1);
    run_cmd("after_illegal", 3'd0, 4'h1, 4'h0, 8'h02, 1'b0, 1'b0, 2);

    // Held start: single ops re-trigger every 3 cycles.
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.op = 3'd3; bus_if.a = 4'h3; bus_if.b = 4'h4;
    n_done = 0;
    repeat (9) begin
      @(negedge clk);
      if (bus_if.done) n_done++;
    end
    bus_if.start = 1'b0;
    check("held_start_dones", n_done, 3);
    repeat (3) @(negedge clk);
    check("held_start_idle", bus_if.busy, 1'b0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000");
    $fatal(1);
  end

endmodule
